sobel_hls_udiv_19ns_11ns_19_seq: RTL
====================================

SOBEL_HLS_UDIV_19NS_11NS_19_SEQ -- requirements
Module: sobel_hls_udiv_19ns_11ns_19_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier (no functional effect).
REQ-002 SHALL have parameter din0_WIDTH, default 19, dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 11, divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 19, quotient width (equals din0_WIDTH).
REQ-005 SHALL have port ap_clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port din0, input, din0_WIDTH: unsigned dividend.
REQ-008 SHALL have port din1, input, din1_WIDTH: unsigned divisor.
REQ-009 SHALL have port in_valid, input, 1: operands valid.
REQ-010 SHALL have port in_ready, output, 1: block can accept operands.
REQ-011 SHALL have port quot, output, dout_WIDTH: unsigned quotient.
REQ-012 SHALL have port rem, output, din1_WIDTH: unsigned remainder.
REQ-013 SHALL have port div_by_zero, output, 1: result produced with din1 == 0.
REQ-014 SHALL have port out_valid, output, 1: quot/rem/div_by_zero valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, both registered-state decodes.
REQ-018 SHALL accept operands on a rising edge with in_valid && in_ready: latch din0, din1, clear partial remainder, load count = din0_WIDTH-1, enter BUSY.
REQ-019 SHALL, in BUSY, perform one restoring step per cycle, MSB first: shift next dividend bit into a (din1_WIDTH+1)-bit partial remainder; if partial >= divisor, subtract and set quotient bit 1, else quotient bit 0.
REQ-020 SHALL enter DONE on the edge that completes the step with count == 0; out_valid is high exactly din0_WIDTH (19) cycles after the accepting edge.
REQ-021 SHALL hold quot, rem, div_by_zero stable while out_valid && !out_ready.
REQ-022 SHALL return to IDLE on the edge with out_valid && out_ready; next acceptance no earlier than the following edge (in_ready never high in DONE).
REQ-023 SHALL ignore in_valid and operand changes while BUSY or DONE.
REQ-024 SHALL, for din1 == 0, keep the same 19-cycle latency and output quot = all ones, rem = din0[din1_WIDTH-1:0], div_by_zero = 1.
REQ-025 SHALL guarantee for din1 != 0: quot*din1 + rem == din0, rem < din1, div_by_zero = 0.
REQ-026 SHALL keep quot and rem outputs at last completed result between operations (not cleared on leaving DONE).

Reset
REQ-027 SHALL, on ap_rst high, asynchronously force state = IDLE, count = 0, quot = 0, rem = 0, div_by_zero = 0, out_valid = 0, in_ready = 1 after deassertion.
REQ-028 SHALL abandon any in-flight division when reset asserts mid-BUSY or mid-DONE; no result is produced for it.
REQ-029 SHALL accept no operands during an edge on which ap_rst is high.

Structure
REQ-030 SHALL place widths defaults and the FSM state encoding (IDLE=0, BUSY=1, DONE=2, 2-bit) in shared package sobel_hls_div_pkg.
REQ-031 SHALL implement the single restoring step as combinational sub-module sobel_hls_udiv_step (inputs partial remainder, dividend bit, divisor; outputs next partial, quotient bit).
REQ-032 SHALL use no multiplier or division operator in synthesised logic.

Verification
REQ-033 SHALL verify 100000 / 7 -> quot = 14285, rem = 5, div_by_zero = 0, out_valid 19 cycles after acceptance.
REQ-034 SHALL verify 521985 / 2047 -> quot = 255, rem = 0; and 524287 / 1 -> quot = 524287, rem = 0.
REQ-035 SHALL verify 5 / 2047 -> quot = 0, rem = 5; and 1234 / 0 -> quot = 0x7FFFF, rem = 1234, div_by_zero = 1, same latency.
REQ-036 SHALL verify backpressure: out_ready low 5 cycles in DONE -> outputs and out_valid held unchanged, in_ready low; out_ready high -> IDLE next edge.
REQ-037 SHALL verify ap_rst pulsed 8 cycles after acceptance -> out_valid never asserts for that operation, in_ready = 1 after release, next division (60 / 7 -> 8 r 4) correct.
REQ-038 SHALL run 10,000 random operand pairs with random in_valid/out_ready against a reference model checking REQ-024/REQ-025.

Source files
------------

// File: rtl/sobel_hls_div_pkg.sv
// sobel_hls_div_pkg: shared width defaults and FSM state encoding for the sequential divider
package sobel_hls_div_pkg;
  localparam int DIN0_W = 19;
  localparam int DIN1_W = 11;
  localparam int DOUT_W = 19;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sobel_hls_udiv_step.sv
// sobel_hls_udiv_step: one restoring-division step (partial, dividend bit, divisor -> next partial, quotient bit)
module sobel_hls_udiv_step
  import sobel_hls_div_pkg::*;
#(
  parameter int W = DIN1_W
) (
  input  logic [W:0]   partial,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   partial_next,
  output logic         q_bit
);
  logic [W+1:0] shifted;
  assign shifted      = {partial, bit_in};
  assign q_bit        = shifted >= {2'b00, divisor};
  assign partial_next = q_bit ? shifted[W:0] - {1'b0, divisor} : shifted[W:0];
endmodule

// File: rtl/sobel_hls_udiv_19ns_11ns_19_seq.sv
// sobel_hls_udiv_19ns_11ns_19_seq: valid/ready sequential restoring divider, one quotient bit per cycle (ap_clk, ap_rst, din0/din1/in_valid/in_ready in, quot/rem/div_by_zero/out_valid/out_ready out)
module sobel_hls_udiv_19ns_11ns_19_seq
  import sobel_hls_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int CW = $clog2(din0_WIDTH);
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [din0_WIDTH-1:0] work;
  logic [din1_WIDTH:0] partial, pn;
  logic [din1_WIDTH-1:0] divisor;
  logic qb;
  sobel_hls_udiv_step #(.W(din1_WIDTH)) u_step (
    .partial(partial),
    .bit_in(work[din0_WIDTH-1]),
    .divisor(divisor),
    .partial_next(pn),
    .q_bit(qb)
  );
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid) ? BUSY :
              (state == BUSY && count == '0) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  // work shifts dividend bits out at the top while quotient bits enter at the bottom
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      count       <= '0;
      work        <= '0;
      partial     <= '0;
      divisor     <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      work    <= din0;
      divisor <= din1;
      partial <= '0;
      count   <= CW'(din0_WIDTH - 1);
    end else if (state == BUSY) begin
      work    <= {work[din0_WIDTH-2:0], qb};
      partial <= pn;
      count   <= count - 1'b1;
      if (count == '0) begin
        quot        <= dout_WIDTH'({work[din0_WIDTH-2:0], qb});
        rem         <= pn[din1_WIDTH-1:0];
        div_by_zero <= divisor == '0;
      end
    end
endmodule
